shot_entry_decoder: RTL and testbench

SHOT_ENTRY_DECODER -- requirements
Module: shot_entry_decoder

---
 rtl/shot_entry_pkg.sv | 25 ++
 rtl/scan_code_classifier.sv | 38 +++
 rtl/shot_entry_decoder.sv | 150 +++++++++++++++
 tb/tb_shot_entry_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shot_entry_pkg.sv
// Shared constants and types for the battleship shot-entry keyboard decoder.
// SHOT_ENTRY_KEYPAD_EN (used in scan_code_classifier) adds numeric-keypad digits.
package shot_entry_pkg;

  localparam logic [3:0] NO_SEL = 4'hF;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Element [i] is the make code for index i (row A..J, digit 0..9).
  localparam logic [9:0][7:0] SC_ROW = {8'h3B, 8'h43, 8'h33, 8'h34, 8'h2B,
                                        8'h24, 8'h23, 8'h21, 8'h32, 8'h1C};
  localparam logic [9:0][7:0] SC_DIG = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                        8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
  localparam logic [9:0][7:0] SC_KPD = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                        8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

  typedef enum logic [1:0] {IDLE, HAVE_ROW, HAVE_BOTH, COMMIT} state_e;

  typedef enum logic [2:0] {ROW, DIGIT, ENTER, BKSP, ESC, OTHER} key_kind_e;

endpackage

// File: rtl/scan_code_classifier.sv
// Combinational map from a PS/2 make code to key kind plus 0..9 index.
// SHOT_ENTRY_KEYPAD_EN: keypad digits also classify as DIGIT.
module scan_code_classifier
  import shot_entry_pkg::*;
#(
  parameter int BOARD_SIZE = 10
) (
  input  logic [7:0] scanCode,
  output key_kind_e  kind,
  output logic [3:0] index
);

  always_comb begin
    kind  = OTHER;
    index = 4'h0;
    if (scanCode == SC_ENTER)     kind = ENTER;
    else if (scanCode == SC_BKSP) kind = BKSP;
    else if (scanCode == SC_ESC)  kind = ESC;
    // Keys beyond the board edge fall through as OTHER (silently ignored).
    for (int i = 0; i < 10; i++) begin
      if (i < BOARD_SIZE && scanCode == SC_ROW[i]) begin
        kind  = ROW;
        index = 4'(i);
      end
      if (i < BOARD_SIZE && scanCode == SC_DIG[i]) begin
        kind  = DIGIT;
        index = 4'(i);
      end
`ifdef SHOT_ENTRY_KEYPAD_EN
      if (i < BOARD_SIZE && scanCode == SC_KPD[i]) begin
        kind  = DIGIT;
        index = 4'(i);
      end
`endif
    end
  end

endmodule

// File: rtl/shot_entry_decoder.sv
// Turns PS/2 keystrokes (row letter, column digit, Enter) into a valid/ready shot.
// SHOT_ENTRY_KEYPAD_EN enables keypad digits via scan_code_classifier.
module shot_entry_decoder
  import shot_entry_pkg::*;
#(
  parameter int BOARD_SIZE = 10
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic [7:0] scanCode,
  input  logic       scanValid,
  input  logic       shotReady,
  output logic       shotValid,
  output logic [3:0] shotRow,
  output logic [3:0] shotCol,
  output logic [3:0] letter,
  output logic [3:0] number,
  output logic       entryError,
  output logic [7:0] shotCount
);

  state_e     state_q, state_d;
  logic       brk_q, brk_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic [3:0] srow_q, srow_d, scol_q, scol_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  key_kind_e  kind;
  logic [3:0] idx;

  scan_code_classifier #(.BOARD_SIZE(BOARD_SIZE)) u_cls (
    .scanCode (scanCode),
    .kind     (kind),
    .index    (idx)
  );

  always_ff @(posedge clock50) begin
    if (reset) begin
      state_q <= IDLE;
      brk_q   <= 1'b0;
      row_q   <= NO_SEL;
      col_q   <= NO_SEL;
      srow_q  <= 4'h0;
      scol_q  <= 4'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      brk_q   <= brk_d;
      row_q   <= row_d;
      col_q   <= col_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    brk_d   = brk_q;
    row_d   = row_q;
    col_d   = col_q;
    srow_d  = srow_q;
    scol_d  = scol_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (state_q == COMMIT && shotReady) begin
      state_d = IDLE;
      cnt_d   = cnt_q + 8'd1;
      row_d   = NO_SEL;
      col_d   = NO_SEL;
    end

    if (scanValid) begin
      // Break tracking runs in every state so a key release during COMMIT
      // cannot leak its make code into the next entry.
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (scanCode == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (scanCode != SC_EXT && state_q != COMMIT) begin
        if (kind == ESC) begin
          state_d = IDLE;
          row_d   = NO_SEL;
          col_d   = NO_SEL;
        end else begin
          case (state_q)
            IDLE: begin
              case (kind)
                ROW: begin
                  row_d   = idx;
                  state_d = HAVE_ROW;
                end
                DIGIT, ENTER: err_d = 1'b1;
                default: ;
              endcase
            end
            HAVE_ROW: begin
              case (kind)
                ROW: row_d = idx;
                DIGIT: begin
                  col_d   = idx;
                  state_d = HAVE_BOTH;
                end
                ENTER: err_d = 1'b1;
                BKSP: begin
                  row_d   = NO_SEL;
                  state_d = IDLE;
                end
                default: ;
              endcase
            end
            HAVE_BOTH: begin
              case (kind)
                DIGIT: col_d = idx;
                ROW: begin
                  row_d   = idx;
                  col_d   = NO_SEL;
                  state_d = HAVE_ROW;
                end
                BKSP: begin
                  col_d   = NO_SEL;
                  state_d = HAVE_ROW;
                end
                ENTER: begin
                  srow_d  = row_q;
                  scol_d  = col_q;
                  state_d = COMMIT;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign shotValid  = (state_q == COMMIT);
  assign shotRow    = srow_q;
  assign shotCol    = scol_q;
  assign letter     = row_q;
  assign number     = col_q;
  assign entryError = err_q;
  assign shotCount  = cnt_q;

endmodule

// File: tb/tb_shot_entry_decoder.sv
// Directed keystroke sequences; shots and error pulses checked by a queue-based monitor.
module tb_shot_entry_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scanCode;
  logic       scanValid;
  logic       shotReady;
  logic       shotValid;
  logic [3:0] shotRow, shotCol, letter, number;
  logic       entryError;
  logic [7:0] shotCount;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       is_err;
    logic [3:0] row;
    logic [3:0] col;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  shot_entry_decoder #(.BOARD_SIZE(10)) dut (
    .clock50    (clk),
    .reset      (reset),
    .scanCode   (scanCode),
    .scanValid  (scanValid),
    .shotReady  (shotReady),
    .shotValid  (shotValid),
    .shotRow    (shotRow),
    .shotCol    (shotCol),
    .letter     (letter),
    .number     (number),
    .entryError (entryError),
    .shotCount  (shotCount)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(posedge clk); #1;
    scanCode  = c;
    scanValid = 1'b1;
    @(posedge clk); #1;
    scanValid = 1'b0;
  endtask

  task automatic push_err();
    q.push_back('{1'b1, 4'h0, 4'h0});
  endtask

  task automatic push_shot(input logic [3:0] r, input logic [3:0] c);
    q.push_back('{1'b0, r, c});
  endtask

  // Monitor: every error pulse and every cycle of a pending shot consumes/peeks the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (entryError) begin
        n_vec++;
        if (q.size() == 0 || !q[0].is_err) begin
          n_bad++;
          $display("FAIL err_unexpected: got entryError=1 expected no error");
        end else begin
          void'(q.pop_front());
        end
      end
      if (shotValid) begin
        n_vec++;
        if (q.size() == 0 || q[0].is_err) begin
          n_bad++;
          $display("FAIL shot_unexpected: got row=%h col=%h expected none", shotRow, shotCol);
        end else begin
          if (shotRow !== q[0].row || shotCol !== q[0].col) begin
            n_bad++;
            $display("FAIL shot_value: got row=%h col=%h expected row=%h col=%h",
                     shotRow, shotCol, q[0].row, q[0].col);
          end
          if (shotReady) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; scanCode = 8'h00; scanValid = 1'b0; shotReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {7'd0, shotValid}, 8'd0);
    check("rst_row", {4'd0, shotRow}, 8'd0);
    check("rst_col", {4'd0, shotCol}, 8'd0);
    check("rst_letter", {4'd0, letter}, 8'h0F);
    check("rst_number", {4'd0, number}, 8'h0F);
    check("rst_err", {7'd0, entryError}, 8'd0);
    check("rst_count", shotCount, 8'd0);
    reset = 1'b0;

    // Simple shot with consumer always ready.
    shotReady = 1'b1;
    send(8'h1C); send(8'h16);
    push_shot(4'd0, 4'd1);
    send(8'h5A);
    check("s1_valid_n1", {7'd0, shotValid}, 8'd1);
    @(posedge clk); #1;
    check("s1_valid_drop", {7'd0, shotValid}, 8'd0);
    check("s1_count", shotCount, 8'd1);
    check("s1_letter", {4'd0, letter}, 8'h0F);
    check("s1_number", {4'd0, number}, 8'h0F);

    // Back-pressured shot; keys during COMMIT dropped, F0 still arms break.
    shotReady = 1'b0;
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h2E);
    check("s2_letter", {4'd0, letter}, 8'h00);
    check("s2_number", {4'd0, number}, 8'h05);
    push_shot(4'd0, 4'd5);
    send(8'h5A);
    send(8'h32);
    send(8'hF0);
    check("s2_hold_valid", {7'd0, shotValid}, 8'd1);
    check("s2_hold_letter", {4'd0, letter}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    shotReady = 1'b1;
    @(posedge clk); #1;
    shotReady = 1'b0;
    check("s2_valid_drop", {7'd0, shotValid}, 8'd0);
    check("s2_count", shotCount, 8'd2);
    check("s2_letter_f", {4'd0, letter}, 8'h0F);
    send(8'h32);
    check("s2_break_discard", {4'd0, letter}, 8'h0F);
    send(8'h32);
    check("s2_after_break", {4'd0, letter}, 8'h01);
    send(8'h76);

    // Errors in IDLE.
    push_err();
    send(8'h5A);
    check("e1_valid", {7'd0, shotValid}, 8'd0);
    check("e1_letter", {4'd0, letter}, 8'h0F);
    @(posedge clk); #1;
    check("e1_one_cycle", {7'd0, entryError}, 8'd0);
    push_err();
    send(8'h16);
    check("e2_number", {4'd0, number}, 8'h0F);

    // Display tracking through edit keys.
    send(8'h3B); check("d1", {letter, number}, 8'h9F);
    send(8'h46); check("d2", {letter, number}, 8'h99);
    send(8'h66); check("d3", {letter, number}, 8'h9F);
    send(8'h16); check("d4", {letter, number}, 8'h91);
    send(8'h76); check("d5", {letter, number}, 8'hFF);

    // Enter with only a row, then row replaces a full selection.
    send(8'h1C);
    push_err();
    send(8'h5A);
    check("r1", {letter, number}, 8'h0F);
    send(8'h16); send(8'h32);
    check("r2", {letter, number}, 8'h1F);
    send(8'h76);

    // E0 prefix ignored, unknown code ignored silently.
    send(8'h1C); send(8'hE0); send(8'h16);
    check("x1", {letter, number}, 8'h01);
    send(8'h29);
    check("x2", {letter, number}, 8'h01);
    send(8'h76);

    // Keypad digit.
    send(8'h1C); send(8'h70);
`ifdef SHOT_ENTRY_KEYPAD_EN
    check("kp", {letter, number}, 8'h00);
`else
    check("kp", {letter, number}, 8'h0F);
`endif
    send(8'h76);

    // Reset while a shot is pending, colliding with a key and shotReady.
    send(8'h32); send(8'h1E);
    push_shot(4'd1, 4'd2);
    send(8'h5A);
    check("c1_valid", {7'd0, shotValid}, 8'd1);
    reset = 1'b1; scanCode = 8'h1C; scanValid = 1'b1; shotReady = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; scanValid = 1'b0; shotReady = 1'b0;
    check("c1_valid_rst", {7'd0, shotValid}, 8'd0);
    check("c1_count_rst", shotCount, 8'd0);
    check("c1_letter_rst", {4'd0, letter}, 8'h0F);
    check("c1_row_rst", {4'd0, shotRow}, 8'd0);
    q.delete();

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 8'(q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
